// File: rtl/serial_addsub_if.sv
// Serial a/b operand bus between the operand generators and the bit-serial adder/subtractor.
// The master drives the operand bits and start/mode. The slave returns the serial and
// parallel results.
interface serial_addsub_if #(
  parameter int unsigned W = 8
);
  logic         start;
  logic         sub;
  logic         bit_valid;
  logic         a_in;
  logic         b_in;
  logic         busy;
  logic         s_out;
  logic         s_valid;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  modport master (
    output start, sub, bit_valid, a_in, b_in,
    input  busy, s_out, s_valid, done, result, cout, ovf
  );

  modport slave (
    input  start, sub, bit_valid, a_in, b_in,
    output busy, s_out, s_valid, done, result, cout, ovf
  );
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor. Operands arrive LSB first, one bit per
// accepted cycle. Subtraction adds ~B with the carry preset to 1.
module serial_addsub #(
  parameter int unsigned W = 8
) (
  input logic             clk,
  input logic             rst_n,
  serial_addsub_if.slave  bus
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          mode_q, mode_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] count_q, count_d;
  logic          s_out_q, s_out_d;
  logic          s_valid_q, s_valid_d;
  logic [W-1:0]  result_q, result_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic bb;
  logic sum_bit;
  logic carry_nx;
  logic last_bit;

  // Full-adder slice: B is inverted in subtract mode.
  always_comb begin
    bb       = bus.b_in ^ mode_q;
    sum_bit  = bus.a_in ^ bb ^ carry_q;
    carry_nx = (bus.a_in & bb) | (bus.a_in & carry_q) | (bb & carry_q);
    last_bit = (count_q == CW'(W - 1));
  end

  // Next-state logic for the IDLE -> RUN -> DONE sequence and the datapath registers.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    carry_d   = carry_q;
    count_d   = count_q;
    s_out_d   = s_out_q;
    s_valid_d = 1'b0;
    result_d  = result_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      StIdle: begin
        // A bit presented alongside start is deliberately not consumed.
        if (bus.start) begin
          state_d = StRun;
          mode_d  = bus.sub;
          carry_d = bus.sub;
          count_d = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      StRun: begin
        if (bus.bit_valid) begin
          carry_d   = carry_nx;
          s_out_d   = sum_bit;
          s_valid_d = 1'b1;
          result_d  = {sum_bit, result_q[W-1:1]};
          count_d   = count_q + CW'(1);
          if (last_bit) begin
            state_d = StDone;
            count_d = '0;
            cout_d  = carry_nx;
            // carry_q here is the carry into the MSB.
            ovf_d   = carry_q ^ carry_nx;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mode_q    <= 1'b0;
      carry_q   <= 1'b0;
      count_q   <= '0;
      s_out_q   <= 1'b0;
      s_valid_q <= 1'b0;
      result_q  <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      carry_q   <= carry_d;
      count_q   <= count_d;
      s_out_q   <= s_out_d;
      s_valid_q <= s_valid_d;
      result_q  <= result_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.busy    = (state_q == StRun);
  assign bus.done    = (state_q == StDone);
  assign bus.s_out   = s_out_q;
  assign bus.s_valid = s_valid_q;
  assign bus.result  = result_q;
  assign bus.cout    = cout_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Bit-serial two's-complement adder/subtractor built from one half-adder pair and a carry flop.
- Consumes two operands serially, LSB first, one bit per accepted cycle.
- Emits the sum serially, and presents the parallel result, carry and overflow when the last bit is done.
- Sits downstream of the serial stimulus/operand generators in the lab datapath. It is the responding end of that serial a/b bit interface.

Parameters:
- W, 8, operand and result width in bits (W >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins an operation when idle.
- sub  input  1  mode, sampled on accepted start: 0 = add (A+B), 1 = subtract (A-B).
- bit_valid  input  1  a_in/b_in carry a valid operand bit this cycle.
- a_in  input  1  serial operand A bit, LSB first.
- b_in  input  1  serial operand B bit, LSB first.
- busy  output  1  operation in progress (RUN state).
- s_out  output  1  registered serial sum bit.
- s_valid  output  1  s_out valid this cycle.
- done  output  1  one-cycle pulse; result, cout and ovf are valid.
- result  output  W  parallel sum/difference, held until next accepted start.
- cout  output  1  final carry out (for subtract: 1 = no borrow).
- ovf  output  1  signed overflow (carry into MSB XOR carry out).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, s_out, s_valid, done, cout, ovf = 0; result = 0; carry flop = 0; bit counter = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 → RUN.
  - Latch sub into mode_q; carry <= sub; count <= 0; busy=1 from the next cycle.
  - bit_valid is ignored in IDLE.
- RUN:
  - Each cycle with bit_valid=1:
    - bb = b_in ^ mode_q
    - s = a_in ^ bb ^ carry
    - carry <= majority(a_in, bb, carry)
    - s_out <= s; s_valid <= 1 on the next cycle
    - result <= {s, result[W-1:1]} (shift right)
    - count increments.
  - Cycles with bit_valid=0 are stalls: no state change, s_valid=0 next cycle.
  - On the cycle accepting bit W-1 (count = W-1):
    - Capture carry_in_msb = current carry.
    - Go to DONE.
- DONE (exactly one cycle):
  - done=1, busy=0.
  - The last s_valid coincides with done.
  - cout = final carry; ovf = carry_in_msb ^ final carry.
  - Next state is IDLE unconditionally.
  - start in DONE is ignored.
- Latency:
  - s_out lags the accepted input bit by 1 cycle.
  - done asserts 1 cycle after the W-th bit is accepted.
  - Minimum operation is W+1 cycles after start (start cycle plus W bit cycles); done follows immediately.
- start while busy (RUN): ignored; mode and carry are unchanged.
- start and bit_valid in the same IDLE cycle: the start is accepted and that bit is not consumed. The first operand bit must come on a later cycle.
- result, cout and ovf hold their values from DONE until the next accepted start. On accepted start, cout and ovf clear to 0. result is overwritten progressively by shifting.
- Reset asserted mid-operation: immediate return to the reset values above; no done is produced.
- Arithmetic is modulo 2^W. Subtract is A + ~B + 1.

Test Plan:
- W=8, add, A=0x03, B=0x05, continuous bit_valid:
  - s_out sequence LSB first = 0,0,0,1,0,0,0,0.
  - done 1 cycle after the 8th bit; result=0x08, cout=0, ovf=0.
- Add, A=0xC8 (200), B=0x64 (100): result=0x2C, cout=1, ovf=0.
- Add, A=0x7F, B=0x01: result=0x80, cout=0, ovf=1.
- Subtract:
  - A=0x05, B=0x03 → result=0x02, cout=1, ovf=0.
  - A=0x03, B=0x05 → result=0xFE, cout=0, ovf=0.
  - A=0x80, B=0x01 → result=0x7F, ovf=1.
- Add 0x03+0x05 with bit_valid deasserted for 3 cycles after bits 2 and 5, plus a start pulse mid-RUN:
  - Identical result 0x08.
  - s_valid has gaps matching the stalls.
  - Mode is not altered and done is not early.
- rst_n pulsed low after 4 accepted bits:
  - All outputs are 0 immediately (asynchronously).
  - No done follows.
  - A fresh start then computes 0x0A+0x01 = 0x0B correctly.
